fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Multi-cycle instruction-fetch controller for the 16-bit core.
- Owns the architectural PC register and sequences instruction-memory requests with a req/ready handshake.
- Delivers fetched instructions to decode with a valid/ready handshake.
- Applies taken-branch/jump redirects from the PC-control datapath, squashes wrong-path fetches, and stops on HALT.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset; bit 0 must be 0.
- WIDTH, 16, address/instruction width; fixed at 16 in this core.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  16  fetch address
- imem_ready  in  1  memory returns imem_data this cycle (may be same cycle as req)
- imem_data  in  16  fetched instruction
- inst_valid  out  1  instruction available to decode
- inst  out  16  instruction word
- inst_pc  out  16  address of inst
- inst_pc_plus2  out  16  inst_pc+2, for link/branch-base use
- dec_ready  in  1  decode accepts inst this cycle
- redirect_valid  in  1  taken branch/jump from execute (1-cycle pulse)
- redirect_pc  in  16  redirect target; bit 0 ignored (forced 0)
- halt  in  1  decode accepted a HALT (1-cycle pulse)
- halted  out  1  fetch stopped

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC, state=IDLE, imem_req=0, inst_valid=0, inst=0, inst_pc=0, inst_pc_plus2=0, halted=0, squash=0, pend_pc=0.
- States: IDLE, FETCH, DELIVER, HALTED. Encoding is in the package.
- IDLE:
  - Exactly one cycle after reset release, then go to FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_addr is held stable while imem_req=1 and imem_ready=0.
- FETCH, imem_ready=1, squash=0:
  - Capture inst=imem_data, inst_pc=pc, inst_pc_plus2=pc+2.
  - pc<=pc+2; go to DELIVER.
- FETCH, redirect_valid arrives while not ready:
  - Set squash=1 and pend_pc=redirect_pc; imem_addr is unchanged.
  - A later redirect while squash=1 overwrites pend_pc (newest wins).
- FETCH, imem_ready=1, squash=1 (or redirect_valid in that same cycle):
  - Discard data; pc<=target; squash<=0; stay in FETCH, new address next cycle.
  - If redirect_valid is present that cycle, target=redirect_pc; otherwise target=pend_pc.
- DELIVER:
  - inst_valid=1; inst, inst_pc and inst_pc_plus2 are held stable until accepted; imem_req=0.
- DELIVER, dec_ready=1, redirect_valid=0: go to FETCH next cycle.
- DELIVER, redirect_valid=1 (with or without dec_ready):
  - Delivered instruction is wrong-path: inst_valid<=0, pc<=redirect_pc, go to FETCH.
- halt=1 (any state except HALTED) with no redirect_valid that cycle:
  - In DELIVER: inst_valid<=0, go to HALTED.
  - In FETCH: set halt_pend; stay until imem_ready, discard the data, then go to HALTED.
  - The memory transaction is never abandoned mid-handshake.
- halt and redirect_valid in the same cycle: redirect wins (older instruction), halt is ignored.
- HALTED:
  - halted=1, imem_req=0, inst_valid=0; redirect and halt are ignored; only reset exits.
- Arithmetic:
  - PC increments by 2, modulo 2^16; 16'hFFFE wraps to 16'h0000.
  - redirect_pc[0] is treated as 0.
- Throughput: with imem_ready tied 1 and dec_ready tied 1, one instruction per 2 cycles.
- Reset mid-transaction: state drops immediately and the outstanding request is abandoned; memory must tolerate an imem_req drop on reset.

Decomposition:
- Package fetch_pkg holds:
  - State encoding (IDLE=2'd0, FETCH=2'd1, DELIVER=2'd2, HALTED=2'd3).
  - RESET_PC default.
  - PC_STEP=16'd2.
- Sub-module pc_incr: 16-bit +2 adder with wrap, used for pc+2 and inst_pc_plus2.
- FSM, PC register, squash/pending logic and output registers stay in fetch_sequencer.

Test Plan:
- Reset then imem_ready=1, dec_ready=1, imem_data=16'hA000+addr:
  - IDLE 1 cycle; first imem_addr=0x0000; inst stream 0xA000, 0xA002, 0xA004 with inst_pc_plus2 = inst_pc+2.
- imem_ready low 3 cycles on addr 0x0004, with redirect_valid pulsed to 0x0100 in cycle 2:
  - imem_addr stays 0x0004 until ready; returned data is discarded (no inst_valid).
  - Next imem_addr=0x0100.
- inst_valid held with dec_ready=0 for 4 cycles:
  - inst/inst_pc are stable and no imem_req.
  - redirect to 0x0203 in cycle 3: inst_valid drops, next imem_addr=0x0202.
- PC=0xFFFE fetch accepted -> next imem_addr=0x0000.
- Halt cases:
  - halt in DELIVER: halted=1 next cycle, imem_req stays 0 for 20 cycles despite redirect pulses.
  - halt during pending fetch: halted asserts only after imem_ready.
- halt and redirect_valid (0x0040) in the same cycle -> no halt; next fetch at 0x0040.
- rst pulled low asynchronously mid-FETCH (between clock edges) -> outputs go to their reset values immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

   localparam logic [15:0] RESET_PC_DEF = 16'h0000;
   localparam logic [15:0] PC_STEP      = 16'd2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_DELIVER = 2'd2,
      ST_HALTED  = 2'd3
   } fetch_state_t;

   // Instruction word plus its address context, as handed to decode.
   typedef struct packed {
      logic [15:0] inst;
      logic [15:0] pc;
      logic [15:0] pc_plus2;
   } fetch_rsp_t;

endpackage

// File: rtl/pc_incr.sv
// Next-sequential-PC adder; wraps modulo 2^16 (0xFFFE -> 0x0000).
module pc_incr
   import fetch_pkg::*;
(
   input  logic [15:0] pc_i,
   output logic [15:0] pc_o
);

   assign pc_o = pc_i + PC_STEP;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, runs the imem req/ready handshake, hands
// instructions to decode, and handles redirects, wrong-path squash and HALT.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [15:0] RESET_PC = RESET_PC_DEF,
   parameter int          WIDTH    = 16
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_ready,
   input  logic [WIDTH-1:0] imem_data,
   output logic             inst_valid,
   output logic [WIDTH-1:0] inst,
   output logic [WIDTH-1:0] inst_pc,
   output logic [WIDTH-1:0] inst_pc_plus2,
   input  logic             dec_ready,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc,
   input  logic             halt,
   output logic             halted
);

   fetch_state_t     state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
   logic             squash_q, squash_d;
   logic             halt_pend_q, halt_pend_d;
   logic             req_q, req_d;
   logic             vld_q, vld_d;
   logic             halted_q, halted_d;
   fetch_rsp_t       rsp_q, rsp_d;
   logic [WIDTH-1:0] pc_plus2;
   logic [WIDTH-1:0] redir_tgt;

   assign redir_tgt = redirect_pc & {{(WIDTH-1){1'b1}}, 1'b0};

   pc_incr u_pc_incr (
      .pc_i (pc_q),
      .pc_o (pc_plus2)
   );

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      pend_pc_d   = pend_pc_q;
      squash_d    = squash_q;
      halt_pend_d = halt_pend_q;
      req_d       = req_q;
      vld_d       = vld_q;
      halted_d    = halted_q;
      rsp_d       = rsp_q;
      case (state_q)
         ST_IDLE: begin
            state_d = ST_FETCH;
            req_d   = 1'b1;
         end
         ST_FETCH: begin
            if (imem_ready) begin
               // Transaction completes; a redirect seen now beats everything.
               squash_d    = 1'b0;
               halt_pend_d = 1'b0;
               if (redirect_valid) begin
                  pc_d = redir_tgt;
               end else if (halt_pend_q || halt) begin
                  state_d  = ST_HALTED;
                  req_d    = 1'b0;
                  halted_d = 1'b1;
               end else if (squash_q) begin
                  pc_d = pend_pc_q;
               end else begin
                  rsp_d   = '{inst: imem_data, pc: pc_q, pc_plus2: pc_plus2};
                  pc_d    = pc_plus2;
                  state_d = ST_DELIVER;
                  req_d   = 1'b0;
                  vld_d   = 1'b1;
               end
            end else if (redirect_valid) begin
               // Address must stay put mid-handshake; remember the target.
               squash_d    = 1'b1;
               pend_pc_d   = redir_tgt;
               halt_pend_d = 1'b0;
            end else if (halt) begin
               halt_pend_d = 1'b1;
            end
         end
         ST_DELIVER: begin
            if (redirect_valid) begin
               vld_d   = 1'b0;
               pc_d    = redir_tgt;
               state_d = ST_FETCH;
               req_d   = 1'b1;
            end else if (halt) begin
               vld_d    = 1'b0;
               state_d  = ST_HALTED;
               halted_d = 1'b1;
            end else if (dec_ready) begin
               vld_d   = 1'b0;
               state_d = ST_FETCH;
               req_d   = 1'b1;
            end
         end
         ST_HALTED: begin
            req_d    = 1'b0;
            vld_d    = 1'b0;
            halted_d = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            vld_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         pc_q        <= RESET_PC;
         pend_pc_q   <= '0;
         squash_q    <= 1'b0;
         halt_pend_q <= 1'b0;
         req_q       <= 1'b0;
         vld_q       <= 1'b0;
         halted_q    <= 1'b0;
         rsp_q       <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pend_pc_q   <= pend_pc_d;
         squash_q    <= squash_d;
         halt_pend_q <= halt_pend_d;
         req_q       <= req_d;
         vld_q       <= vld_d;
         halted_q    <= halted_d;
         rsp_q       <= rsp_d;
      end
   end

   assign imem_req      = req_q;
   assign imem_addr     = pc_q;
   assign inst_valid    = vld_q;
   assign inst          = rsp_q.inst;
   assign inst_pc       = rsp_q.pc;
   assign inst_pc_plus2 = rsp_q.pc_plus2;
   assign halted        = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized run, all
// checked cycle by cycle against a behavioural model of the fetch rules.
module tb_fetch_sequencer;

   localparam logic [15:0] RST_PC = 16'h0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ready;
   logic [15:0] imem_data;
   logic        inst_valid;
   logic [15:0] inst;
   logic [15:0] inst_pc;
   logic [15:0] inst_pc_plus2;
   logic        dec_ready;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        halt;
   logic        halted;

   int n_chk  = 0;
   int n_fail = 0;

   fetch_sequencer #(.RESET_PC(RST_PC), .WIDTH(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_data      (imem_data),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_pc_plus2  (inst_pc_plus2),
      .dec_ready      (dec_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .halted         (halted)
   );

   always #5 clk = ~clk;

   // Instruction memory contents are a fixed function of the address.
   function automatic logic [15:0] memf(input logic [15:0] a);
      return 16'((int'(a) + 32'hA000) % 65536);
   endfunction

   assign imem_data = memf(imem_addr);

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: what the fetch unit is doing, by the fetch rules.
   bit          m_idle, m_fetch, m_hold, m_stop, m_kill, m_stop_pend;
   logic [15:0] m_pc, m_kill_pc, e_inst, e_pc, e_pc2;

   task automatic model_reset();
      m_idle = 1; m_fetch = 0; m_hold = 0; m_stop = 0;
      m_kill = 0; m_stop_pend = 0;
      m_pc = RST_PC; m_kill_pc = '0;
      e_inst = '0; e_pc = '0; e_pc2 = '0;
   endtask

   task automatic model_next(input bit r, input bit d, input bit rv,
                             input logic [15:0] rpc, input bit h);
      logic [15:0] tgt;
      tgt = 16'(int'(rpc) / 2 * 2);
      if (m_idle) begin
         m_idle = 0; m_fetch = 1;
      end else if (m_fetch) begin
         if (r) begin
            if (rv) m_pc = tgt;
            else if (m_stop_pend || h) begin m_fetch = 0; m_stop = 1; end
            else if (m_kill) m_pc = m_kill_pc;
            else begin
               e_inst = memf(m_pc);
               e_pc   = m_pc;
               e_pc2  = 16'((int'(m_pc) + 2) % 65536);
               m_pc   = e_pc2;
               m_fetch = 0; m_hold = 1;
            end
            m_kill = 0; m_stop_pend = 0;
         end else if (rv) begin
            m_kill = 1; m_kill_pc = tgt; m_stop_pend = 0;
         end else if (h) begin
            m_stop_pend = 1;
         end
      end else if (m_hold) begin
         if (rv) begin m_hold = 0; m_fetch = 1; m_pc = tgt; end
         else if (h) begin m_hold = 0; m_stop = 1; end
         else if (d) begin m_hold = 0; m_fetch = 1; end
      end
   endtask

   task automatic model_check();
      chk("req", 16'(imem_req), 16'(m_fetch));
      chk("valid", 16'(inst_valid), 16'(m_hold));
      chk("halted", 16'(halted), 16'(m_stop));
      if (m_fetch) chk("addr", imem_addr, m_pc);
      if (m_hold) begin
         chk("inst", inst, e_inst);
         chk("inst_pc", inst_pc, e_pc);
         chk("inst_pc2", inst_pc_plus2, e_pc2);
      end
   endtask

   task automatic rst_chk(input string tag);
      chk({tag, "_req"}, 16'(imem_req), 16'd0);
      chk({tag, "_valid"}, 16'(inst_valid), 16'd0);
      chk({tag, "_halted"}, 16'(halted), 16'd0);
      chk({tag, "_addr"}, imem_addr, RST_PC);
      chk({tag, "_inst"}, inst, 16'd0);
      chk({tag, "_pc"}, inst_pc, 16'd0);
      chk({tag, "_pc2"}, inst_pc_plus2, 16'd0);
   endtask

   // Called at a falling edge: drive, advance one cycle, check at next fall.
   task automatic step(input bit r, input bit d, input bit rv,
                       input logic [15:0] rpc, input bit h);
      imem_ready = r; dec_ready = d; redirect_valid = rv;
      redirect_pc = rpc; halt = h;
      model_next(r, d, rv, rpc, h);
      @(posedge clk);
      @(negedge clk);
      model_check();
   endtask

   task automatic do_reset();
      imem_ready = 0; dec_ready = 0; redirect_valid = 0;
      redirect_pc = '0; halt = 0;
      rst = 0;
      @(negedge clk);
      rst = 1;
      model_reset();
      model_check();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int stop_cnt;
      rst = 0; imem_ready = 0; dec_ready = 0; redirect_valid = 0;
      redirect_pc = '0; halt = 0;
      #7 rst_chk("por");
      @(negedge clk);
      rst = 1;
      model_reset();
      model_check();

      // Streaming with memory and decode always ready.
      step(1, 1, 0, '0, 0);
      chk("first_addr", imem_addr, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 0, '0, 0);
         chk("s_inst", inst, 16'(16'hA000 + 2 * i));
         chk("s_pc2", inst_pc_plus2, 16'(inst_pc + 2));
         step(1, 1, 0, '0, 0);
      end
      step(1, 1, 0, '0, 0);
      step(1, 0, 1, 16'h0004, 0);
      chk("back_addr", imem_addr, 16'h0004);

      // Stall on 0x0004 with a redirect during the stall.
      step(0, 1, 0, '0, 0);
      chk("stall1_addr", imem_addr, 16'h0004);
      step(0, 1, 1, 16'h0100, 0);
      chk("stall2_addr", imem_addr, 16'h0004);
      step(0, 1, 0, '0, 0);
      chk("stall3_addr", imem_addr, 16'h0004);
      step(1, 1, 0, '0, 0);
      chk("squash_valid", 16'(inst_valid), 16'd0);
      chk("squash_addr", imem_addr, 16'h0100);

      // Decode back-pressure then a redirect while holding.
      step(1, 0, 0, '0, 0);
      chk("hold_inst", inst, 16'hA100);
      for (int i = 0; i < 2; i++) begin
         step(1, 0, 0, '0, 0);
         chk("hold_inst", inst, 16'hA100);
         chk("hold_pc", inst_pc, 16'h0100);
         chk("hold_req", 16'(imem_req), 16'd0);
      end
      step(1, 0, 1, 16'h0203, 0);
      chk("hredir_valid", 16'(inst_valid), 16'd0);
      chk("hredir_addr", imem_addr, 16'h0202);

      // PC wrap at 0xFFFE.
      step(1, 1, 1, 16'hFFFF, 0);
      chk("wrap_fetch", imem_addr, 16'hFFFE);
      step(1, 1, 0, '0, 0);
      chk("wrap_pc2", inst_pc_plus2, 16'h0000);
      step(1, 1, 0, '0, 0);
      chk("wrap_addr", imem_addr, 16'h0000);

      // Halt and redirect together: redirect wins.
      step(1, 0, 0, '0, 0);
      step(1, 0, 1, 16'h0040, 1);
      chk("hr_halted", 16'(halted), 16'd0);
      chk("hr_addr", imem_addr, 16'h0040);

      // Halt while delivering.
      step(1, 0, 0, '0, 0);
      step(1, 0, 0, '0, 1);
      chk("hd_halted", 16'(halted), 16'd1);
      for (int i = 0; i < 20; i++) begin
         step(1, 1, (i % 3) == 0, 16'h0300, 0);
         chk("hd_req", 16'(imem_req), 16'd0);
      end

      // Halt while a fetch is still pending.
      do_reset();
      step(1, 1, 0, '0, 0);
      step(0, 1, 0, '0, 1);
      chk("hp_halted0", 16'(halted), 16'd0);
      step(0, 1, 0, '0, 0);
      chk("hp_halted1", 16'(halted), 16'd0);
      step(1, 1, 0, '0, 0);
      chk("hp_halted2", 16'(halted), 16'd1);
      chk("hp_valid", 16'(inst_valid), 16'd0);

      // Asynchronous reset in the middle of a stalled fetch.
      do_reset();
      step(1, 1, 0, '0, 0);
      step(1, 1, 1, 16'h0400, 0);
      step(0, 1, 0, '0, 0);
      chk("ar_pre_addr", imem_addr, 16'h0400);
      #2 rst = 0;
      #1 rst_chk("arst");
      @(negedge clk);
      rst = 1;
      model_reset();
      model_check();
      step(1, 1, 0, '0, 0);
      chk("ar_restart", imem_addr, RST_PC);

      // Randomized traffic against the model; recover from halts via reset.
      stop_cnt = 0;
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
              $urandom_range(0, 99) < 8, 16'($urandom),
              $urandom_range(0, 99) < 2);
         if (m_stop) stop_cnt++;
         if (stop_cnt >= 5) begin
            stop_cnt = 0;
            do_reset();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
